// File: rtl/mem_io_responder_if.sv
// rtl/mem_io_responder_if.sv - CPU byte bus plus UART side-band bundle for mem_io_responder
interface mem_io_responder_if;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_pop;
  logic        program_finish;

  modport master (
    output mem_a, mem_wr, mem_dout, tx_ready, rx_data, rx_valid,
    input  mem_din, io_buffer_full, tx_data, tx_valid, rx_pop, program_finish
  );

  modport slave (
    input  mem_a, mem_wr, mem_dout, tx_ready, rx_data, rx_valid,
    output mem_din, io_buffer_full, tx_data, tx_valid, rx_pop, program_finish
  );
endinterface

// File: rtl/mem_io_responder.sv
// rtl/mem_io_responder.sv - RAM and memory-mapped UART/counter/stop responder on the CPU byte bus
module mem_io_responder #(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int TX_DEPTH       = 8,
  parameter int FULL_MARGIN    = 2
) (
  input logic             clk_in,
  input logic             rst_in,
  mem_io_responder_if.slave bus
);
  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(TX_DEPTH);
  localparam logic [CW-1:0] FULL_LEVEL = CW'(TX_DEPTH - FULL_MARGIN);

  logic [7:0] ram  [2**RAM_ADDR_WIDTH];
  logic [7:0] fifo [TX_DEPTH];

  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [31:0]   cnt, snap;
  logic [7:0]    din_q;
  logic          finish_q;

  logic                      is_io;
  logic [15:0]               io_off;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr;
  logic                      push, pop, push_ok;
  logic [7:0]                push_data;
  logic                      unused_addr_bits;

  assign is_io            = (bus.mem_a[17:16] == 2'b11);
  assign io_off           = bus.mem_a[15:0];
  assign ram_addr         = bus.mem_a[RAM_ADDR_WIDTH-1:0];
  assign unused_addr_bits = ^bus.mem_a[31:18];

  assign pop = (count != '0) && bus.tx_ready;

  // 0x30000 forwards nonzero bytes; 0x30004 queues the 0x00 stop marker behind them
  always_comb begin
    push      = 1'b0;
    push_data = bus.mem_dout;
    if (is_io && bus.mem_wr) begin
      if (io_off == 16'h0000) begin
        push = (bus.mem_dout != 8'h00);
      end else if (io_off == 16'h0004) begin
        push      = 1'b1;
        push_data = 8'h00;
      end
    end
  end

  assign push_ok = push && ((count != DEPTH_C) || pop);

  always_ff @(posedge clk_in) begin
    if (!is_io && bus.mem_wr) ram[ram_addr] <= bus.mem_dout;
    if (push_ok) fifo[tail] <= push_data;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt      <= 32'd0;
      snap     <= 32'd0;
      din_q    <= 8'h00;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      finish_q <= 1'b0;
    end else begin
      cnt <= cnt + 32'd1;
      if (push_ok) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      if (push_ok && !pop) count <= count + 1'b1;
      else if (pop && !push_ok) count <= count - 1'b1;
      if (is_io && bus.mem_wr && io_off == 16'h0004) finish_q <= 1'b1;
      // read data is held across write cycles and refreshed on every read, idle included
      if (!bus.mem_wr) begin
        if (!is_io) begin
          din_q <= ram[ram_addr];
        end else begin
          case (io_off)
            16'h0000: din_q <= bus.rx_valid ? bus.rx_data : 8'h00;
            16'h0004: begin
              din_q <= cnt[7:0];
              snap  <= cnt;
            end
            16'h0005: din_q <= snap[15:8];
            16'h0006: din_q <= snap[23:16];
            16'h0007: din_q <= snap[31:24];
            default:  din_q <= 8'h00;
          endcase
        end
      end
    end
  end

  assign bus.rx_pop         = !bus.mem_wr && is_io && (io_off == 16'h0000) && bus.rx_valid;
  assign bus.mem_din        = din_q;
  assign bus.tx_valid       = (count != '0);
  assign bus.tx_data        = fifo[head];
  assign bus.io_buffer_full = (count >= FULL_LEVEL);
  assign bus.program_finish = finish_q;
endmodule

// File: tb/tb_mem_io_responder.sv
// tb/tb_mem_io_responder.sv - table-driven and randomized self-checking bench for mem_io_responder
module tb_mem_io_responder;
  localparam int DEPTH   = 8;
  localparam int FULL_AT = 6;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;

  mem_io_responder_if bus();

  mem_io_responder #(
    .RAM_ADDR_WIDTH(17),
    .TX_DEPTH(DEPTH),
    .FULL_MARGIN(2)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus(bus)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  logic [7:0]  m_ram [int];
  logic [7:0]  m_q [$];
  logic [7:0]  seen [$];
  logic [31:0] m_cnt, m_snap;
  logic [7:0]  m_din;
  bit          m_known, m_fin;

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [7:0]  d;
    bit          rv;
    logic [7:0]  rd;
    logic [7:0]  exp_din;
    bit          chk_din;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_cnt   = 32'd0;
    m_snap  = 32'd0;
    m_din   = 8'h00;
    m_known = 1'b1;
    m_fin   = 1'b0;
  endtask

  // One bus transaction: drive, check the combinational pop, clock, check against the model
  task automatic step(input bit wr, input logic [31:0] a, input logic [7:0] d,
                      input bit rdy, input bit rv, input logic [7:0] rd);
    bit          io, pop, push;
    logic [15:0] off;
    int          key;
    logic [7:0]  pd;
    bus.mem_wr   = wr;
    bus.mem_a    = a;
    bus.mem_dout = d;
    bus.tx_ready = rdy;
    bus.rx_valid = rv;
    bus.rx_data  = rd;
    #1;
    io  = (a[17:16] == 2'b11);
    off = a[15:0];
    key = int'(a[16:0]);
    chk("rx_pop", bus.rx_pop, !wr && io && off == 16'h0000 && rv);
    if (bus.tx_valid && rdy) seen.push_back(bus.tx_data);
    pop  = (m_q.size() != 0) && rdy;
    push = 1'b0;
    pd   = 8'h00;
    if (wr) begin
      if (io) begin
        if (off == 16'h0000 && d != 8'h00) begin
          push = 1'b1;
          pd   = d;
        end else if (off == 16'h0004) begin
          push  = 1'b1;
          m_fin = 1'b1;
        end
      end else begin
        m_ram[key] = d;
      end
    end else if (io) begin
      m_known = 1'b1;
      case (off)
        16'h0000: m_din = rv ? rd : 8'h00;
        16'h0004: begin m_din = m_cnt[7:0]; m_snap = m_cnt; end
        16'h0005: m_din = m_snap[15:8];
        16'h0006: m_din = m_snap[23:16];
        16'h0007: m_din = m_snap[31:24];
        default:  m_din = 8'h00;
      endcase
    end else if (m_ram.exists(key)) begin
      m_din   = m_ram[key];
      m_known = 1'b1;
    end else begin
      m_known = 1'b0;
    end
    if (pop) void'(m_q.pop_front());
    if (push && m_q.size() < DEPTH) m_q.push_back(pd);
    m_cnt = m_cnt + 32'd1;
    @(posedge clk_in);
    #1;
    if (m_known) chk("mem_din", bus.mem_din, m_din);
    chk("tx_valid", bus.tx_valid, m_q.size() != 0);
    if (m_q.size() != 0) chk("tx_data", bus.tx_data, m_q[0]);
    chk("io_buffer_full", bus.io_buffer_full, m_q.size() >= FULL_AT);
    chk("program_finish", bus.program_finish, m_fin);
  endtask

  initial begin
    logic [31:0] base, got;
    bus.mem_wr   = 1'b0;
    bus.mem_a    = 32'h10;
    bus.mem_dout = 8'h00;
    bus.tx_ready = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    vecs[0]  = '{1'b1, 32'h0000_0010, 8'hA5, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 8'h00, 1'b0, 8'h00, 8'hA5, 1'b1};
    vecs[2]  = '{1'b1, 32'h0001_FFFF, 8'h3C, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[3]  = '{1'b0, 32'h0001_FFFF, 8'h00, 1'b0, 8'h00, 8'h3C, 1'b1};
    vecs[4]  = '{1'b0, 32'h0003_0000, 8'h00, 1'b0, 8'h55, 8'h00, 1'b1};
    vecs[5]  = '{1'b0, 32'h0003_0000, 8'h00, 1'b1, 8'h7E, 8'h7E, 1'b1};
    vecs[6]  = '{1'b1, 32'h0003_0008, 8'hFF, 1'b0, 8'h00, 8'h7E, 1'b1};
    vecs[7]  = '{1'b0, 32'h0003_0008, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1};
    vecs[8]  = '{1'b0, 32'h0002_0010, 8'h00, 1'b0, 8'h00, 8'hA5, 1'b1};
    vecs[9]  = '{1'b0, 32'hFFFC_0010, 8'h00, 1'b0, 8'h00, 8'hA5, 1'b1};
    vecs[10] = '{1'b1, 32'h0001_FFFE, 8'h81, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[11] = '{1'b0, 32'h0001_FFFE, 8'h00, 1'b0, 8'h00, 8'h81, 1'b1};

    #1 rst_in = 1'b1;
    #1;
    chk("reset_mem_din", bus.mem_din, 8'h00);
    chk("reset_tx_valid", bus.tx_valid, 1'b0);
    chk("reset_full", bus.io_buffer_full, 1'b0);
    chk("reset_finish", bus.program_finish, 1'b0);
    @(posedge clk_in);
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    model_reset();

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].wr, vecs[i].a, vecs[i].d, 1'b1, vecs[i].rv, vecs[i].rd);
      if (vecs[i].chk_din) chk($sformatf("vec%0d_din", i), bus.mem_din, vecs[i].exp_din);
    end

    seen.delete();
    step(1'b1, 32'h30000, 8'h41, 1'b1, 1'b0, 8'h00);
    step(1'b1, 32'h30000, 8'h00, 1'b1, 1'b0, 8'h00);
    step(1'b1, 32'h30000, 8'h42, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h10, 8'h00, 1'b1, 1'b0, 8'h00);
    chk("uart_count", seen.size(), 2);
    if (seen.size() == 2) begin
      chk("uart_byte0", seen[0], 8'h41);
      chk("uart_byte1", seen[1], 8'h42);
    end

    seen.delete();
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 32'h30000, 8'(i), 1'b0, 1'b0, 8'h00);
      if (i == 5) chk("bp_full_after5", bus.io_buffer_full, 1'b0);
      if (i == 6) chk("bp_full_after6", bus.io_buffer_full, 1'b1);
    end
    step(1'b1, 32'h30000, 8'h99, 1'b0, 1'b0, 8'h00);
    step(1'b1, 32'h30000, 8'h77, 1'b1, 1'b0, 8'h00);
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 32'h10, 8'h00, 1'b1, 1'b0, 8'h00);
      if (k == 2) chk("bp_full_count6", bus.io_buffer_full, 1'b1);
      if (k == 3) chk("bp_full_count5", bus.io_buffer_full, 1'b0);
    end
    chk("bp_drain_count", seen.size(), 9);
    if (seen.size() == 9) begin
      for (int i = 0; i < 8; i++) chk($sformatf("bp_byte%0d", i), seen[i], i + 1);
      chk("bp_byte_on_full_pop", seen[8], 8'h77);
    end

    for (int i = 0; i < 300; i++) step(1'b0, 32'h10, 8'h00, 1'b1, 1'b0, 8'h00);
    base = m_cnt;
    got  = 32'd0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h30004 + i, 8'h00, 1'b1, 1'b0, 8'h00);
      got[i*8 +: 8] = bus.mem_din;
    end
    chk("cnt_snapshot", got, base);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      bit          wr;
      logic [7:0]  d;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: a = 32'($urandom_range(0, 15));
        4, 5:       a = 32'h30000;
        6:          a = 32'h30004 + 32'($urandom_range(0, 3));
        7:          a = 32'h30010;
        8:          a = 32'h20000 | 32'($urandom_range(0, 15));
        default:    a = 32'hABC0_0000 | 32'($urandom_range(0, 15));
      endcase
      wr = ($urandom_range(0, 1) == 1);
      if (wr && a == 32'h30004 && $urandom_range(0, 3) != 0) wr = 1'b0;
      d = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      step(wr, a, d, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, 8'($urandom));
    end
    for (int i = 0; i < 10; i++) step(1'b0, 32'h10, 8'h00, 1'b1, 1'b0, 8'h00);

    rst_in = 1'b1;
    #2 rst_in = 1'b0;
    model_reset();
    seen.delete();
    step(1'b1, 32'h30000, 8'h33, 1'b0, 1'b0, 8'h00);
    step(1'b1, 32'h30004, 8'hAB, 1'b0, 1'b0, 8'h00);
    chk("finish_rise", bus.program_finish, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h10, 8'h00, 1'b1, 1'b0, 8'h00);
    chk("stop_drain_count", seen.size(), 2);
    if (seen.size() == 2) chk("stop_byte", seen[1], 8'h00);
    step(1'b1, 32'h30000, 8'h55, 1'b0, 1'b0, 8'h00);
    step(1'b0, 32'h1FFFF, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("pre_reset_tx_valid", bus.tx_valid, 1'b1);
    #3 rst_in = 1'b1;
    #1;
    chk("async_tx_valid", bus.tx_valid, 1'b0);
    chk("async_finish", bus.program_finish, 1'b0);
    chk("async_mem_din", bus.mem_din, 8'h00);
    chk("async_full", bus.io_buffer_full, 1'b0);
    @(posedge clk_in);
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    model_reset();
    step(1'b0, 32'h1FFFF, 8'h00, 1'b1, 1'b0, 8'h00);
    chk("ram_kept_over_reset", bus.mem_din, 8'h3C);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h10, 8'h00, 1'b1, 1'b0, 8'h00);
    step(1'b0, 32'h30004, 8'h00, 1'b1, 1'b0, 8'h00);
    chk("cnt_after_reset", bus.mem_din, 8'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
